// File: rtl/key_tick_gen.sv
// key_tick_gen: key synchronizer/debouncer, run/fast toggles and tick prescaler
// for the two-digit date counter. Everything runs in the single clk domain.
// Build option: define KEY_DEBOUNCE_EN to enable the debounce filter; without
// it the debounced key state is the synchronized key registered once.
module key_tick_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned SLOW_DIV        = 10000000,
    parameter int unsigned FAST_DIV        = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] key_n,
    output logic [1:0] key_press,
    output logic       run_en,
    output logic       fast_sel,
    output logic       tick,
    output logic       clear,
    output logic       blink
);

    localparam int unsigned PW = $clog2(SLOW_DIV);
    localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_DIV - 1);
    localparam logic [PW-1:0] FAST_LAST = PW'(FAST_DIV - 1);
    localparam logic [PW-1:0] SLOW_HALF = PW'(SLOW_DIV / 2);
    localparam logic [PW-1:0] FAST_HALF = PW'(FAST_DIV / 2);

    logic [1:0]    sync_meta;
    logic [1:0]    sync;
    logic [1:0]    db;
    logic [1:0]    key_fall;
    logic          run_d;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] div_last;
    logic [PW-1:0] div_half;

    // Two-flop synchronizer per key; idle level is released (high).
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= '1;
            sync      <= '1;
        end else begin
            sync_meta <= key_n;
            sync      <= sync_meta;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [DW-1:0] db_cnt [2];
    logic [1:0]    accept;

    // A key change is accepted once it has differed from db for DEBOUNCE_CYCLES cycles.
    always_comb begin
        accept = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            accept[i] = (sync[i] != db[i]) && (db_cnt[i] == DB_LAST);
        end
        key_fall = accept & ~sync;
    end

    // Per-key stability counter; any return to the db level restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            db <= '1;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if ((sync[i] == db[i]) || accept[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
                if (accept[i]) begin
                    db[i] <= sync[i];
                end
            end
        end
    end
`else
    // Filter bypassed: db simply follows the synchronized key one cycle later.
    always_comb begin
        key_fall = db & ~sync;
    end

    // Debounced state register without filtering.
    always_ff @(posedge clk) begin
        if (reset) begin
            db <= '1;
        end else begin
            db <= sync;
        end
    end
`endif

    // Press pulses and the run/fast toggles they drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_press <= '0;
            run_en    <= 1'b0;
            fast_sel  <= 1'b0;
            run_d     <= 1'b0;
        end else begin
            key_press <= key_fall;
            run_en    <= run_en ^ key_press[0];
            fast_sel  <= fast_sel ^ key_press[1];
            run_d     <= run_en;
        end
    end

    // Current divider terminal count and blink threshold.
    always_comb begin
        div_last = fast_sel ? FAST_LAST : SLOW_LAST;
        div_half = fast_sel ? FAST_HALF : SLOW_HALF;
        blink    = run_en && (pcnt < div_half);
    end

    // Prescaler. The stop edge (run_en about to fall) and the rate-switch edge
    // both restart pcnt and drop the tick, so no tick lands while stopped and
    // the first tick at the new rate comes a full DIV after the switch.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt  <= '0;
            tick  <= 1'b0;
            clear <= 1'b0;
        end else begin
            clear <= run_d & ~run_en;
            if (!run_en || key_press[0] || key_press[1]) begin
                pcnt <= '0;
                tick <= 1'b0;
            end else if (pcnt == div_last) begin
                pcnt <= '0;
                tick <= 1'b1;
            end else begin
                pcnt <= pcnt + PW'(1);
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_tick_gen.sv
// Directed self-checking bench for key_tick_gen (DEBOUNCE_CYCLES=4, SLOW_DIV=8,
// FAST_DIV=2). Expected press latency and bounce behaviour follow KEY_DEBOUNCE_EN.
module tb_key_tick_gen;

    localparam int unsigned DB   = 4;
    localparam int unsigned SLOW = 8;
    localparam int unsigned FAST = 2;
`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned LAT = DB + 2;
    localparam int unsigned BOUNCE_PRESSES = 0;
`else
    localparam int unsigned LAT = 3;
    localparam int unsigned BOUNCE_PRESSES = 2;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] key_n = 2'b11;
    logic [1:0] key_press;
    logic       run_en;
    logic       fast_sel;
    logic       tick;
    logic       clear;
    logic       blink;
    logic [6:0] outs;

    assign outs = {key_press, run_en, fast_sel, tick, clear, blink};

    always #5 clk = ~clk;

    key_tick_gen #(
        .DEBOUNCE_CYCLES(DB),
        .SLOW_DIV(SLOW),
        .FAST_DIV(FAST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_n(key_n),
        .key_press(key_press),
        .run_en(run_en),
        .fast_sel(fast_sel),
        .tick(tick),
        .clear(clear),
        .blink(blink)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Pulse counters sampled on the falling edge.
    int   press0_cnt = 0;
    int   press1_cnt = 0;
    int   clear_cnt  = 0;
    int   dbl_cnt    = 0;
    logic tick_prev  = 1'b0;

    always @(negedge clk) begin
        if (key_press[0] === 1'b1) press0_cnt++;
        if (key_press[1] === 1'b1) press1_cnt++;
        if (clear === 1'b1) clear_cnt++;
        if ((tick === 1'b1) && (tick_prev === 1'b1)) dbl_cnt++;
        tick_prev = tick;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        int p0;
        int p1;
        int c0;
        int d0;
        int held;

        // Reset and idle
        reset = 1'b1;
        repeat (3) step;
        check_val("reset_outs", 32'(outs), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step;
            check_val("idle_outs", 32'(outs), 32'd0);
        end

        // Clean key 0 press: start running slow
        p0 = press0_cnt;
        key_n[0] = 1'b0;
        repeat (LAT - 1) step;
        check_val("press0_early", 32'(key_press), 32'd0);
        step;
        check_val("press0_pulse", 32'(key_press), 32'd1);
        check_val("run_before", 32'(run_en), 32'd0);
        step;
        check_val("press0_done", 32'(key_press), 32'd0);
        check_val("run_on", 32'(run_en), 32'd1);
        check_val("tick_at_rise", 32'(tick), 32'd0);
        check_val("blink_at_rise", 32'(blink), 32'd1);
        held = LAT + 1;
        for (int j = 1; j <= 16; j++) begin
            step;
            held++;
            if (held == 10) key_n[0] = 1'b1;
            check_val("slow_tick", 32'(tick), 32'((j % 8) == 0));
            check_val("slow_blink", 32'(blink), 32'((j % 8) < 4));
        end
        check_val("single_press0", 32'(press0_cnt - p0), 32'd1);
        check_val("slow_fast_sel", 32'(fast_sel), 32'd0);

        // Bouncy key 0: 3 low / 1 high / 3 low
        p0 = press0_cnt;
        key_n[0] = 1'b0;
        repeat (3) step;
        key_n[0] = 1'b1;
        step;
        key_n[0] = 1'b0;
        repeat (3) step;
        key_n[0] = 1'b1;
        repeat (15) step;
        check_val("bounce_presses", 32'(press0_cnt - p0), 32'(BOUNCE_PRESSES));
        check_val("bounce_run", 32'(run_en), 32'd1);

        // Key 1 while running: switch to fast
        d0 = dbl_cnt;
        p1 = press1_cnt;
        key_n[1] = 1'b0;
        repeat (LAT) step;
        check_val("press1_pulse", 32'(key_press), 32'd2);
        check_val("fast_before", 32'(fast_sel), 32'd0);
        step;
        check_val("fast_on", 32'(fast_sel), 32'd1);
        check_val("tick_at_switch", 32'(tick), 32'd0);
        check_val("blink_at_switch", 32'(blink), 32'd1);
        for (int j = 1; j <= 6; j++) begin
            step;
            check_val("fast_tick", 32'(tick), 32'((j % 2) == 0));
            check_val("fast_blink", 32'(blink), 32'((j % 2) == 0));
        end
        key_n[1] = 1'b1;
        repeat (LAT + 2) step;
        check_val("no_double_tick", 32'(dbl_cnt - d0), 32'd0);
        check_val("single_press1", 32'(press1_cnt - p1), 32'd1);

        // Key 0 while running: stop and clear
        c0 = clear_cnt;
        key_n[0] = 1'b0;
        repeat (LAT) step;
        check_val("stop_pulse", 32'(key_press), 32'd1);
        check_val("run_still_on", 32'(run_en), 32'd1);
        step;
        check_val("run_off", 32'(run_en), 32'd0);
        check_val("tick_at_stop", 32'(tick), 32'd0);
        check_val("clear_early", 32'(clear), 32'd0);
        check_val("blink_at_stop", 32'(blink), 32'd0);
        step;
        check_val("clear_pulse", 32'(clear), 32'd1);
        check_val("tick_in_clear", 32'(tick), 32'd0);
        key_n[0] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step;
            check_val("stopped_outs", 32'({run_en, tick, clear, blink}), 32'd0);
        end
        check_val("single_clear", 32'(clear_cnt - c0), 32'd1);

        // Both keys together, then reset during a later debounce
        key_n = 2'b00;
        repeat (LAT) step;
        check_val("both_pulse", 32'(key_press), 32'd3);
        step;
        check_val("both_run", 32'(run_en), 32'd1);
        check_val("both_fast", 32'(fast_sel), 32'd0);
        key_n = 2'b11;
        repeat (LAT + 2) step;
        p0 = press0_cnt;
        key_n[0] = 1'b0;
        repeat (2) step;
        reset = 1'b1;
        key_n = 2'b11;
        step;
        check_val("reset_mid_outs", 32'(outs), 32'd0);
        step;
        check_val("reset_hold_outs", 32'(outs), 32'd0);
        reset = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step;
            check_val("post_reset_outs", 32'(outs), 32'd0);
        end
        check_val("no_press_after_reset", 32'(press0_cnt - p0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
